// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared types and constants for the data-memory Wishbone master.
//   state_e  : bus FSM encoding (IDLE/REQ/WAIT/DONE)
//   wb_wr_t  : registered write-side bus payload (we, sel, data)
//   wb_sel() : byte-select for a request (loads read the whole word)
// -----------------------------------------------------------------------------
package rv32i_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;
  localparam int unsigned TMO_CNT_W = 16;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_DATA_W-1:0] data;
  } wb_wr_t;

  // Stores use the caller's byte mask; loads always fetch the full word.
  function automatic logic [WB_SEL_W-1:0] wb_sel(input logic                wr,
                                                 input logic [WB_SEL_W-1:0] mask);
    return wr ? mask : WB_SEL_ALL;
  endfunction

endpackage

// File: rtl/rv32i_dmem_wb_master_if.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_wb_master_if
// Single-beat pipelined-Wishbone bus between the data-memory master and a slave.
//   master drives : cyc, stb, we, addr, wdata, sel
//   slave drives  : stall, ack, err, rdata
// -----------------------------------------------------------------------------
interface rv32i_dmem_wb_master_if #(
  parameter int unsigned ADDR_W = 32
);
  import rv32i_pkg::*;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [ADDR_W-1:0]    addr;
  logic [WB_DATA_W-1:0] wdata;
  logic [WB_SEL_W-1:0]  sel;
  logic                 stall;
  logic                 ack;
  logic                 err;
  logic [WB_DATA_W-1:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, err, rdata
  );

endinterface

// File: rtl/rv32i_bus_timeout.sv
// -----------------------------------------------------------------------------
// rv32i_bus_timeout
// Clear/enable cycle counter that flags when a bus transaction has been
// outstanding for TIMEOUT_CYCLES cycles (counting from 0 on the first cycle).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : hold count at 0 (asserted while no transaction is open)
//   i_en           : count this cycle
//   o_expired      : registered; high while count == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module rv32i_bus_timeout
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMO_CNT_W-1:0] CNT_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] cnt_q;
  logic [TMO_CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + TMO_CNT_W'(1);

  // Expired is precomputed one cycle ahead so the flag is a flop, not a compare.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      o_expired <= 1'b0;
    end else if (i_clear) begin
      cnt_q     <= '0;
      o_expired <= (CNT_LAST == '0);
    end else if (i_en && !o_expired) begin
      cnt_q     <= cnt_inc;
      o_expired <= (cnt_inc == CNT_LAST);
    end
  end

endmodule

// File: rtl/rv32i_dmem_wb_master.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_wb_master
// Data-memory bus master behind the memory-access stage. Each request becomes
// one single-beat pipelined-Wishbone transaction; the pipeline is stalled until
// the transaction completes, then released for exactly one cycle (DONE).
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_req, i_wr           : request pending, 1=store/0=load
//   i_addr                : byte address (bits [1:0] ignored)
//   i_wr_data, i_wr_mask  : mask-aligned store data and byte enables
//   o_rd_data             : load data, valid with o_done, held until next DONE
//   o_done, o_err         : completion pulse and error/timeout flag
//   o_stall               : combinational pipeline hold
//   wb                    : Wishbone master port
// -----------------------------------------------------------------------------
module rv32i_dmem_wb_master
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic                 i_wr,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [WB_DATA_W-1:0] i_wr_data,
  input  logic [WB_SEL_W-1:0]  i_wr_mask,
  output logic [WB_DATA_W-1:0] o_rd_data,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_stall,
  rv32i_dmem_wb_master_if.master wb
);

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  wb_wr_t               wr_q, wr_d;
  logic [WB_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic in_txn;
  logic accept;
  logic resp_window;
  logic got_err;
  logic got_ack;
  logic timed_out;
  logic expired;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];

  // Response qualification: ack/err only count once the strobe is accepted.
  assign in_txn      = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign accept      = (state_q == ST_REQ) && !wb.stall;
  assign resp_window = accept || (state_q == ST_WAIT);
  assign got_err     = resp_window && wb.err;
  assign got_ack     = resp_window && wb.ack && !wb.err;
  assign timed_out   = in_txn && expired && !got_err && !got_ack;

  // Transaction watchdog, cleared whenever no transaction is open.
  rv32i_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!in_txn),
    .i_en      (in_txn),
    .o_expired (expired)
  );

  // State register and registered bus/response outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      addr_q    <= '0;
      wr_q      <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          addr_d    = {i_addr[ADDR_W-1:2], 2'b00};
          wr_d.we   = i_wr;
          wr_d.sel  = wb_sel(i_wr, i_wr_mask);
          wr_d.data = i_wr_data;
          if (i_wr && (i_wr_mask == '0)) begin
            // Nothing to write: complete locally without touching the bus.
            state_d   = ST_DONE;
            done_d    = 1'b1;
            err_d     = 1'b0;
            rd_data_d = '0;
          end else begin
            state_d = ST_REQ;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
          end
        end
      end

      ST_REQ, ST_WAIT: begin
        if (got_ack || got_err || timed_out) begin
          state_d   = ST_DONE;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          done_d    = 1'b1;
          err_d     = got_err || timed_out;
          rd_data_d = (got_ack && !wr_q.we) ? wb.rdata : '0;
        end else if (accept) begin
          state_d = ST_WAIT;
          stb_d   = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = wr_q.we;
  assign wb.addr  = addr_q;
  assign wb.wdata = wr_q.data;
  assign wb.sel   = wr_q.sel;

  assign o_rd_data = rd_data_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

  // Reset-gated so the pipeline is never held while the master is in reset.
  assign o_stall = i_rst_n && (((state_q == ST_IDLE) && i_req) || in_txn);

endmodule
